envelope_led_meter: RTL and testbench

//  Peak-hold bar-graph meter for the Tang Nano 9K demod lab. Consumes unsigned AM envelope

---
 rtl/envelope_if.sv | 11 +
 rtl/envelope_led_meter.sv | 121 ++++++++++++
 tb/tb_envelope_led_meter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/envelope_if.sv
// Envelope sample stream (valid/ready) from the demodulator into the LED meter.
interface envelope_if #(
  parameter int unsigned DATA_W = 12
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/envelope_led_meter.sv
// Peak-hold, timed-decay 6 dB/step bar-graph meter driving four LEDs.
// Optional clip blink on LED[3] when CLIP_BLINK_EN is defined.
module envelope_led_meter #(
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned HOLD_CYCLES  = 13_500_000,
  parameter int unsigned DECAY_CYCLES = 2_700_000,
  parameter int unsigned CLIP_CYCLES  = 27_000_000
) (
  input  logic       clk_27m,
  input  logic       rst_n,
  envelope_if.slave  s,
  output logic [3:0] LED
);

  localparam int unsigned HOLD_W  = $clog2((HOLD_CYCLES  < 2) ? 2 : HOLD_CYCLES);
  localparam int unsigned DECAY_W = $clog2((DECAY_CYCLES < 2) ? 2 : DECAY_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   peak, peak_d;
  logic [HOLD_W-1:0]   hold_cnt, hold_d;
  logic [DECAY_W-1:0]  decay_cnt, decay_d;
  logic [3:0]          led_d;
  logic                accept;

  assign accept = s.s_valid && s.s_ready;

  // State register plus registered ready and LED outputs
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      peak      <= '0;
      hold_cnt  <= '0;
      decay_cnt <= '0;
      s.s_ready <= 1'b0;
      LED       <= 4'b0000;
    end else begin
      state     <= state_d;
      peak      <= peak_d;
      hold_cnt  <= hold_d;
      decay_cnt <= decay_d;
      s.s_ready <= 1'b1;
      LED       <= led_d;
    end
  end

  // Hold/decay sequencing; a refresh overrides any decay tick in the same cycle
  always_comb begin
    state_d = state;
    peak_d  = peak;
    hold_d  = hold_cnt;
    decay_d = decay_cnt;

    case (state)
      HOLD: begin
        if (hold_cnt == '0) begin
          state_d = DECAY;
          decay_d = DECAY_W'(DECAY_CYCLES - 1);
        end else begin
          hold_d = hold_cnt - HOLD_W'(1);
        end
      end
      DECAY: begin
        if (decay_cnt == '0) begin
          peak_d  = peak >> 1;
          decay_d = DECAY_W'(DECAY_CYCLES - 1);
          if (peak_d == '0) state_d = IDLE;
        end else begin
          decay_d = decay_cnt - DECAY_W'(1);
        end
      end
      default: ;
    endcase

    // A zero sample can only tie with a zero peak, which leaves the meter idle
    if (accept && (s.s_data >= peak) && (s.s_data != '0)) begin
      peak_d  = s.s_data;
      hold_d  = HOLD_W'(HOLD_CYCLES - 1);
      state_d = HOLD;
    end
  end

`ifdef CLIP_BLINK_EN
  localparam int unsigned CLIP_W = $clog2((CLIP_CYCLES < 2) ? 2 : CLIP_CYCLES);

  logic [CLIP_W-1:0] clip_cnt;
  logic [21:0]       blink_cnt;

  // Clip window reloads on every full-scale sample; blink counter free-runs
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt  <= '0;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 22'(1);
      if (accept && (s.s_data == '1)) clip_cnt <= CLIP_W'(CLIP_CYCLES - 1);
      else if (clip_cnt != '0)         clip_cnt <= clip_cnt - CLIP_W'(1);
    end
  end
`else
  logic unused_clip;
  assign unused_clip = (CLIP_CYCLES == 0);
`endif

  // Thermometer bar: each LED is a 6 dB threshold on the top four bits
  always_comb begin
    led_d = {peak[DATA_W-1],
             |peak[DATA_W-1:DATA_W-2],
             |peak[DATA_W-1:DATA_W-3],
             |peak[DATA_W-1:DATA_W-4]};
`ifdef CLIP_BLINK_EN
    if (clip_cnt != '0) led_d[3] = blink_cnt[21];
`endif
  end

endmodule

// File: tb/tb_envelope_led_meter.sv
// Self-checking bench for envelope_led_meter: directed scenarios plus random
// samples against a timing-based peak model (age since last refresh).
module tb_envelope_led_meter;

  localparam int unsigned DW    = 12;
  localparam int unsigned HOLD  = 10;
  localparam int unsigned DECAY = 4;
  localparam int unsigned CLIP  = 8;

  logic       clk_27m;
  logic       rst_n;
  logic [3:0] led;

  envelope_if #(.DATA_W(DW)) bus ();

  envelope_led_meter #(
    .DATA_W      (DW),
    .HOLD_CYCLES (HOLD),
    .DECAY_CYCLES(DECAY),
    .CLIP_CYCLES (CLIP)
  ) dut (
    .clk_27m(clk_27m),
    .rst_n  (rst_n),
    .s      (bus.slave),
    .LED    (led)
  );

  initial clk_27m = 1'b0;
  always #5 clk_27m = ~clk_27m;

  int total = 0;
  int bad   = 0;

  // Reference model: peak value, edges since last refresh, acceptance enable
  int unsigned m_peak;
  int unsigned m_age;
  bit          m_ready;
  int unsigned m_clip;
  logic [3:0]  m_led;

  function automatic logic [3:0] bar(input int unsigned p);
    logic [3:0] b;
    b[0] = (p >= (1 << (DW - 4)));
    b[1] = (p >= (1 << (DW - 3)));
    b[2] = (p >= (1 << (DW - 2)));
    b[3] = (p >= (1 << (DW - 1)));
    return b;
  endfunction

  function automatic bit tick_next();
    int unsigned a;
    a = m_age + 1;
    return (m_peak != 0) && (a >= HOLD + DECAY) && (((a - HOLD) % DECAY) == 0);
  endfunction

  // Drive one cycle of input, advance the model across the edge, settle
  task automatic step(input logic v, input logic [DW-1:0] d);
    int unsigned old;
    bit acc;
    bus.s_valid = v;
    bus.s_data  = d;
    @(posedge clk_27m);
    old   = m_peak;
    acc   = v && m_ready;
    m_led = bar(old);
`ifdef CLIP_BLINK_EN
    if (m_clip != 0) m_led[3] = 1'b0;  // blink bit stays low this early after reset
    if (m_clip != 0) m_clip--;
    if (acc && d == {DW{1'b1}}) m_clip = CLIP - 1;
`endif
    m_age++;
    if (old != 0 && m_age >= HOLD + DECAY && ((m_age - HOLD) % DECAY) == 0)
      m_peak = old >> 1;
    if (acc && d >= old && d != 0) begin
      m_peak = d;
      m_age  = 0;
    end
    m_ready = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_27m);
    #1;
    rst_n   = 1'b1;
    m_peak  = 0;
    m_age   = 0;
    m_ready = 1'b0;
    m_clip  = 0;
    m_led   = 4'b0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (led !== 4'b0000) begin bad++; $display("FAIL reset_led got=%b exp=0000", led); end
    total++;
    if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.s_ready); end
    do_reset();
    total++;
    if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b exp=0", bus.s_ready); end
    step(1'b0, '0);
    total++;
    if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b exp=1", bus.s_ready); end
    step(1'b1, 12'h900);
    repeat (3) step(1'b0, '0);
    total++;
    if (led !== 4'b1111) begin bad++; $display("FAIL hold_led got=%b exp=1111", led); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (led !== 4'b0000) begin bad++; $display("FAIL async_reset_led got=%b exp=0000", led); end
    total++;
    if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL async_reset_ready got=%b exp=0", bus.s_ready); end
  endtask

  task automatic test_decay();
    do_reset();
    step(1'b0, '0);
    step(1'b1, 12'h900);
    step(1'b0, '0);
    total++;
    if (led !== 4'b1111) begin bad++; $display("FAIL decay_first got=%b exp=1111", led); end
    for (int i = 0; i < 70; i++) begin
      step(1'b0, '0);
      total++;
      if (led !== m_led) begin bad++; $display("FAIL decay_seq cyc=%0d got=%b exp=%b", i, led, m_led); end
    end
    total++;
    if (led !== 4'b0000) begin bad++; $display("FAIL decay_end got=%b exp=0000", led); end
  endtask

  task automatic test_lower_sample();
    do_reset();
    step(1'b0, '0);
    step(1'b1, 12'h900);
    repeat (3) step(1'b0, '0);
    step(1'b1, 12'h300);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0);
      total++;
      if (led !== m_led) begin bad++; $display("FAIL lower_sample cyc=%0d got=%b exp=%b", i, led, m_led); end
    end
  endtask

  task automatic test_redecay_refresh();
    int n;
    do_reset();
    step(1'b0, '0);
    step(1'b1, 12'h900);
    n = 0;
    while (m_peak != 12'h240 && n < 200) begin step(1'b0, '0); n++; end
    total++;
    if (m_peak != 12'h240) begin bad++; $display("FAIL redecay_reach got=%h exp=240", m_peak); end
    step(1'b1, 12'h500);
    step(1'b0, '0);
    total++;
    if (led !== 4'b0111) begin bad++; $display("FAIL redecay_led got=%b exp=0111", led); end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0);
      total++;
      if (led !== m_led) begin bad++; $display("FAIL redecay_seq cyc=%0d got=%b exp=%b", i, led, m_led); end
    end
  endtask

  task automatic test_tick_tie();
    int n;
    do_reset();
    step(1'b0, '0);
    step(1'b1, 12'h900);
    n = 0;
    while (!(m_peak == 12'h240 && tick_next()) && n < 200) begin step(1'b0, '0); n++; end
    total++;
    if (!(m_peak == 12'h240 && tick_next())) begin bad++; $display("FAIL tie_reach got=%h exp=240", m_peak); end
    step(1'b1, 12'h240);
    // hold restarts: bar must stay 0011 for the full hold plus one decay period
    for (int i = 0; i < HOLD + DECAY; i++) begin
      step(1'b0, '0);
      total++;
      if (led !== 4'b0011) begin bad++; $display("FAIL tie_hold cyc=%0d got=%b exp=0011", i, led); end
    end
    step(1'b0, '0);
    total++;
    if (led !== 4'b0001) begin bad++; $display("FAIL tie_next_step got=%b exp=0001", led); end
  endtask

  task automatic test_clip();
    do_reset();
    step(1'b0, '0);
    step(1'b1, 12'hFFF);
    step(1'b0, '0);
    total++;
`ifdef CLIP_BLINK_EN
    if (led !== 4'b0111) begin bad++; $display("FAIL clip_blink got=%b exp=0111", led); end
`else
    if (led !== 4'b1111) begin bad++; $display("FAIL clip_steady got=%b exp=1111", led); end
`endif
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0);
      total++;
      if (led !== m_led) begin bad++; $display("FAIL clip_seq cyc=%0d got=%b exp=%b", i, led, m_led); end
    end
  endtask

  task automatic test_random();
    logic            v;
    logic [DW-1:0]   d;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 9) == 0);
      d = DW'($urandom_range(0, 4094) >> $urandom_range(0, 11));
      step(v, d);
      total++;
      if (led !== m_led) begin bad++; $display("FAIL random cyc=%0d got=%b exp=%b", i, led, m_led); end
    end
  endtask

  initial begin
    test_reset();
    test_decay();
    test_lower_sample();
    test_redecay_refresh();
    test_tick_tie();
    test_clip();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
